// File: rtl/shield_iic_arbiter.sv
// Round-robin arbiter that shares one Arduino-shield IIC pin pair between several IIC masters.
// Grants only on a free bus and forcibly removes an owner that holds a busy bus too long.
module shield_iic_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int BUS_FREE_CYCLES = 130,
  parameter int TIMEOUT_CYCLES  = 1048576
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_gnt,
  input  logic [NUM_MASTERS-1:0] m_scl_o,
  input  logic [NUM_MASTERS-1:0] m_sda_o,
  input  logic [NUM_MASTERS-1:0] m_scl_t,
  input  logic [NUM_MASTERS-1:0] m_sda_t,
  output logic [NUM_MASTERS-1:0] m_scl_i,
  output logic [NUM_MASTERS-1:0] m_sda_i,
  output logic                   sw2shield_scl_o_out,
  output logic                   sw2shield_scl_t_out,
  output logic                   sw2shield_sda_o_out,
  output logic                   sw2shield_sda_t_out,
  input  logic                   shield2sw_scl_i_in,
  input  logic                   shield2sw_sda_i_in,
  output logic                   bus_busy,
  output logic                   timeout_flag,
  input  logic                   timeout_clr
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int FW = $clog2(BUS_FREE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FREE_MAX = FW'(BUS_FREE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [FW-1:0]          free_q, free_d;
  logic                   busy_q, busy_d;
  logic                   flag_q, flag_d;
  logic                   scl_meta_q, scl_sync_q;
  logic                   sda_meta_q, sda_sync_q, sda_prev_q;

  logic                   start_det, stop_det, bus_free, winner_req, flag_set;
  logic                   win_found;
  logic [PW-1:0]          win_idx;
  int                     idx;

  // Pins are broadcast to every master, granted or not.
  assign m_scl_i = {NUM_MASTERS{shield2sw_scl_i_in}};
  assign m_sda_i = {NUM_MASTERS{shield2sw_sda_i_in}};

  assign start_det  = scl_sync_q &  sda_prev_q & ~sda_sync_q;
  assign stop_det   = scl_sync_q & ~sda_prev_q &  sda_sync_q;
  assign bus_free   = (free_q == FREE_MAX);
  assign winner_req = |(m_req & gnt_q);

  assign m_gnt        = gnt_q;
  assign bus_busy     = busy_q;
  assign timeout_flag = flag_q;

  // NOTE: every output of a combinational block gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (start_det)     busy_d = 1'b1;
    else if (stop_det) busy_d = 1'b0;

    free_d = '0;
    if (state_q != ST_RELEASE && !busy_q && scl_sync_q && sda_sync_q)
      free_d = bus_free ? free_q : free_q + FW'(1);
  end

  // First requester at or above rr_q, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!win_found && m_req[PW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    tmo_d    = tmo_q;
    flag_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (bus_free && win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          rr_d           = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
          state_d        = ST_OWN;
        end
      end
      ST_OWN: begin
        if (stop_det)    tmo_d = '0;
        else if (busy_q) tmo_d = tmo_q + TW'(1);
        // The timeout wins over a simultaneous request drop.
        if (tmo_q == TMO_LAST) begin
          flag_set = 1'b1;
          gnt_d    = '0;
          tmo_d    = '0;
          state_d  = ST_RELEASE;
        end else if (!winner_req && !busy_q) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    flag_d = flag_q;
    if (flag_set)         flag_d = 1'b1;
    else if (timeout_clr) flag_d = 1'b0;
  end

  // Pin mux: only the granted master reaches the IOBUFs; otherwise both lines are released.
  always_comb begin
    sw2shield_scl_o_out = 1'b1;
    sw2shield_scl_t_out = 1'b1;
    sw2shield_sda_o_out = 1'b1;
    sw2shield_sda_t_out = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        sw2shield_scl_o_out = m_scl_o[i];
        sw2shield_scl_t_out = m_scl_t[i];
        sw2shield_sda_o_out = m_sda_o[i];
        sw2shield_sda_t_out = m_sda_t[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      tmo_q      <= '0;
      free_q     <= '0;
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
      // Synchronisers reset to the idle-bus level so no false edge appears after reset.
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      tmo_q      <= tmo_d;
      free_q     <= free_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
      scl_meta_q <= shield2sw_scl_i_in;
      scl_sync_q <= scl_meta_q;
      sda_meta_q <= shield2sw_sda_i_in;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

endmodule
